// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle control FSM. It latches one opcode per fetch handshake, walks it
// through EXEC/MEM/WB, and emits one-cycle datapath strobes plus a retired-instruction count.
module ctrl_sequencer #(
  parameter int OPW     = 3,
  parameter int INSTW   = 9,
  parameter int ALUW    = 3,
  parameter int MEM_LAT = 2,
  parameter int CNTW    = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             instr_valid,
  input  logic [INSTW-1:0] instr,
  output logic             instr_ready,
  input  logic             branch_cond,
  output logic             RegDst,
  output logic             Branch,
  output logic             PcTaken,
  output logic             PcEn,
  output logic             MemtoReg,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic [ALUW-1:0]  ALUOp,
  output logic             Done,
  output logic [CNTW-1:0]  InstCount
);

  localparam int MCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [MCW-1:0] MEM_FIRST = MCW'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_HALT,
    C_ALU
  } op_class_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [MCW-1:0]  cnt_q, cnt_d;
  logic [CNTW-1:0] count_q, count_d;
  op_class_t       op_class;
  logic [ALUW-1:0] alu_code;
  logic            alu_src_imm;
  logic            unused_operand;

  function automatic op_class_t classify(input logic [OPW-1:0] op);
    if (op == OPW'(0)) return C_LOAD;
    if (op == OPW'(1)) return C_STORE;
    if (op == OPW'(2)) return C_BRANCH;
    if (op == OPW'(3)) return C_HALT;
    return C_ALU;
  endfunction

  // Everything downstream decodes from the latched opcode, never from the live instr bus.
  assign op_class       = classify(op_q);
  assign alu_code       = (op_class == C_ALU) ? op_q[ALUW-1:0] : '1;
  assign alu_src_imm    = (op_class == C_ALU) ? ~op_q[1]
                                              : ((op_class == C_LOAD) || (op_class == C_STORE));
  assign unused_operand = ^instr[INSTW-OPW-1:0];

  assign RegDst    = 1'b0;
  assign PcTaken   = Branch & branch_cond;
  assign InstCount = count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values
  // of the others, independent of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no branch of the case can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    count_d     = count_q;
    instr_ready = 1'b0;
    Branch      = 1'b0;
    PcEn        = 1'b0;
    MemtoReg    = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrc      = 1'b0;
    ALUOp       = '1;
    Done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_FETCH;
          count_d = '0;
        end
      end

      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          op_d    = instr[INSTW-1 -: OPW];
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        ALUOp  = alu_code;
        ALUSrc = alu_src_imm;
        case (op_class)
          C_ALU: state_d = S_WB;
          C_LOAD, C_STORE: begin
            state_d = S_MEM;
            cnt_d   = MEM_FIRST;
          end
          C_BRANCH: begin
            Branch  = 1'b1;
            PcEn    = 1'b1;
            count_d = count_q + CNTW'(1);
            state_d = S_FETCH;
          end
          C_HALT: begin
            // HALT retires on the way into DONE; it never advances the PC.
            count_d = count_q + CNTW'(1);
            state_d = S_DONE;
          end
          default: state_d = S_IDLE;
        endcase
      end

      S_MEM: begin
        ALUOp    = alu_code;
        ALUSrc   = 1'b1;
        // The counter is still at its load value only in the first memory cycle.
        MemWrite = (op_class == C_STORE) && (cnt_q == MEM_FIRST);
        MemtoReg = (op_class == C_LOAD);
        if (cnt_q == '0) begin
          if (op_class == C_LOAD) begin
            state_d = S_WB;
          end else begin
            PcEn    = 1'b1;
            count_d = count_q + CNTW'(1);
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - MCW'(1);
        end
      end

      S_WB: begin
        ALUOp    = alu_code;
        ALUSrc   = alu_src_imm;
        RegWrite = 1'b1;
        PcEn     = 1'b1;
        MemtoReg = (op_class == C_LOAD);
        count_d  = count_q + CNTW'(1);
        state_d  = S_FETCH;
      end

      S_DONE: begin
        Done = 1'b1;
        if (Start) begin
          state_d = S_FETCH;
          count_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Datapath invariants: write strobes are exclusive, and a halted core never moves the PC.
  a_wr_exclusive : assert property (@(posedge Clk) disable iff (!Reset_n) !(RegWrite && MemWrite));
  a_done_no_pc   : assert property (@(posedge Clk) disable iff (!Reset_n) Done |-> !PcEn);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed scenarios followed by random traffic. The reference model
// schedules each accepted instruction's strobes from its class latency.
module tb_ctrl_sequencer;
  localparam int OPW   = 3;
  localparam int INSTW = 9;
  localparam int ALUW  = 3;
  localparam int L     = 2;
  localparam int CNTW  = 16;
  localparam int INF   = 32'h3fff_ffff;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             Start = 1'b0;
  logic             instr_valid = 1'b0;
  logic [INSTW-1:0] instr = '0;
  logic             instr_ready;
  logic             branch_cond = 1'b0;
  logic             RegDst, Branch, PcTaken, PcEn, MemtoReg, MemWrite, ALUSrc, RegWrite, Done;
  logic [ALUW-1:0]  ALUOp;
  logic [CNTW-1:0]  InstCount;

  always #5 Clk = ~Clk;

  ctrl_sequencer #(.OPW(OPW), .INSTW(INSTW), .ALUW(ALUW), .MEM_LAT(L), .CNTW(CNTW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .branch_cond(branch_cond), .RegDst(RegDst), .Branch(Branch),
    .PcTaken(PcTaken), .PcEn(PcEn), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .Done(Done), .InstCount(InstCount)
  );

  typedef enum int {K_PCEN, K_REGW, K_MEMW, K_BR, K_M2R, K_RET, K_ALUOP, K_ALUSRC} kind_e;
  typedef struct {
    int        at;
    kind_e     kind;
    logic [2:0] val;
  } ev_t;

  ev_t             evq[$];
  int              cyc = 0;
  int              ready_at = INF;
  int              done_from = -1;
  bit              in_idle = 1'b0;
  bit              known = 1'b0;
  bit              last_hs = 1'b0;
  logic [CNTW-1:0] mdl_count = '0;
  int              n_checks = 0;
  int              n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  function automatic void sched(input int at, input kind_e k, input logic [2:0] v);
    ev_t e;
    e.at = at; e.kind = k; e.val = v;
    evq.push_back(e);
  endfunction

  // Class timing measured from the handshake cycle c.
  function automatic void accept(input logic [2:0] op, input int c);
    sched(c + 1, K_ALUOP, (op >= 3'd4) ? op : 3'b111);
    case (op)
      3'd0: begin
        for (int k = c + 2; k <= c + 1 + L; k++) begin
          sched(k, K_M2R, 3'd0); sched(k, K_ALUSRC, 3'd1);
        end
        sched(c + 2 + L, K_M2R, 3'd0); sched(c + 2 + L, K_REGW, 3'd0);
        sched(c + 2 + L, K_PCEN, 3'd0); sched(c + 2 + L, K_RET, 3'd0);
        ready_at = c + 3 + L;
      end
      3'd1: begin
        for (int k = c + 2; k <= c + 1 + L; k++) sched(k, K_ALUSRC, 3'd1);
        sched(c + 2, K_MEMW, 3'd0);
        sched(c + 1 + L, K_PCEN, 3'd0); sched(c + 1 + L, K_RET, 3'd0);
        ready_at = c + 2 + L;
      end
      3'd2: begin
        sched(c + 1, K_BR, 3'd0); sched(c + 1, K_PCEN, 3'd0); sched(c + 1, K_RET, 3'd0);
        ready_at = c + 2;
      end
      3'd3: begin
        sched(c + 1, K_RET, 3'd0);
        ready_at  = INF;
        done_from = c + 2;
      end
      default: begin
        sched(c + 1, K_ALUSRC, {2'b00, ~op[1]});
        sched(c + 2, K_REGW, 3'd0); sched(c + 2, K_PCEN, 3'd0); sched(c + 2, K_RET, 3'd0);
        ready_at = c + 3;
      end
    endcase
  endfunction

  task automatic run_cycle(input bit rn, input bit st, input bit v,
                           input logic [INSTW-1:0] ins, input bit bc);
    logic [5:0] exp_s;
    logic [2:0] exp_op;
    bit         op_chk, src_chk, exp_src;
    int         rets;
    ev_t        keep[$];
    @(posedge Clk);
    #1;
    Reset_n = rn; Start = st; instr_valid = v; instr = ins; branch_cond = bc;
    @(negedge Clk);
    exp_s = '0; exp_op = 3'b111; op_chk = in_idle; src_chk = 1'b0; exp_src = 1'b0; rets = 0;
    foreach (evq[i]) begin
      if (evq[i].at == cyc) begin
        case (evq[i].kind)
          K_REGW:   exp_s[0] = 1'b1;
          K_MEMW:   exp_s[1] = 1'b1;
          K_M2R:    exp_s[2] = 1'b1;
          K_PCEN:   exp_s[3] = 1'b1;
          K_BR:     exp_s[4] = 1'b1;
          K_RET:    rets++;
          K_ALUOP:  begin op_chk = 1'b1; exp_op = evq[i].val; end
          K_ALUSRC: begin src_chk = 1'b1; exp_src = evq[i].val[0]; end
          default:  ;
        endcase
      end
    end
    last_hs = 1'b0;
    if (known) begin
      check("strobes", 32'({RegDst, Branch, PcEn, MemtoReg, MemWrite, RegWrite}), 32'(exp_s));
      check("instr_ready", 32'(instr_ready), 32'(cyc >= ready_at));
      check("Done", 32'(Done), 32'(done_from >= 0 && cyc >= done_from));
      check("InstCount", 32'(InstCount), 32'(mdl_count));
      check("PcTaken", 32'(PcTaken), 32'(exp_s[4] & bc));
      if (op_chk) check("ALUOp", 32'(ALUOp), 32'(exp_op));
      if (src_chk) check("ALUSrc", 32'(ALUSrc), 32'(exp_src));
    end
    if (!rn) begin
      evq.delete();
      mdl_count = '0; in_idle = 1'b1; ready_at = INF; done_from = -1; known = 1'b1;
    end else if (known) begin
      mdl_count = mdl_count + CNTW'(rets);
      if (st && (in_idle || (done_from >= 0 && cyc >= done_from))) begin
        mdl_count = '0; in_idle = 1'b0; done_from = -1; ready_at = cyc + 1;
      end else if (v && cyc >= ready_at) begin
        last_hs = 1'b1;
        accept(ins[INSTW-1 -: OPW], cyc);
      end
      foreach (evq[i]) if (evq[i].at > cyc) keep.push_back(evq[i]);
      evq = keep;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit bc);
    for (int i = 0; i < n; i++) run_cycle(1'b1, 1'b0, 1'b0, '0, bc);
  endtask

  task automatic start_run();
    run_cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
  endtask

  // Holds the instruction on the bus until the model sees it accepted, bounded to 20 cycles.
  task automatic send(input logic [2:0] op, input bit bc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      run_cycle(1'b1, 1'b0, 1'b1, {op, 6'($urandom)}, bc);
      got = last_hs;
    end
    check("accept", 32'(got), 32'd1);
  endtask

  bit         r_st, r_rn, r_v, idle_like;
  logic [2:0] r_op;

  initial begin
    run_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(2, 1'b0);

    start_run();
    send(3'b101, 1'b0); idle(3, 1'b0);
    send(3'b000, 1'b0); idle(6, 1'b0);
    send(3'b001, 1'b0); idle(5, 1'b0);
    send(3'b010, 1'b0); idle(1, 1'b1); idle(1, 1'b0);
    send(3'b010, 1'b1); idle(1, 1'b0); idle(1, 1'b1);

    // Reset lands in the first MEM cycle of a store; the accumulated count must clear too.
    send(3'b001, 1'b0); idle(1, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(3, 1'b0);

    start_run();
    send(3'b100, 1'b0); send(3'b110, 1'b0); send(3'b111, 1'b0); send(3'b011, 1'b0);
    idle(4, 1'b0);
    start_run();
    idle(3, 1'b0);

    for (int n = 0; n < 4000; n++) begin
      idle_like = in_idle || (done_from >= 0 && cyc >= done_from);
      r_st = idle_like ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);
      r_rn = ($urandom_range(799) != 0);
      r_v  = ($urandom_range(3) != 0);
      r_op = 3'($urandom_range(7));
      if (r_op == 3'd3 && $urandom_range(3) != 0) r_op = 3'($urandom_range(7, 4));
      run_cycle(r_rn, r_st, r_v, {r_op, 6'($urandom)}, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
